// File: rtl/data_memory_be_pkg.sv
// Shared types for the byte-enabled data memory: access sizes, FSM states and
// the load-pipeline payload.
package data_memory_be_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = DATA_W / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  typedef struct packed {
    logic              valid;
    logic              fault;
    logic [1:0]        lane;
    size_e             size;
    logic              uns;
    logic [DATA_W-1:0] word;
  } ld_req_t;

  function automatic logic [LANES-1:0] byte_en(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return 4'b0011 << lane;
      SZ_WORD: return 4'b1111;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_be_lane_align.sv
// Lane alignment: store direction shifts data up to its byte lane; load
// direction shifts the word down and sign/zero-extends to the access size.
module mem_lane_align
  import data_memory_be_pkg::*;
(
  input  logic              load_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        lane_i,
  input  size_e             size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o
);

  logic [4:0]        shamt;
  logic [DATA_W-1:0] sh;

  always_comb begin
    shamt  = {lane_i, 3'b000};
    sh     = data_i >> shamt;
    data_o = data_i << shamt;
    if (load_i) begin
      case (size_i)
        SZ_BYTE: data_o = {{24{~unsigned_i & sh[7]}}, sh[7:0]};
        SZ_HALF: data_o = {{16{~unsigned_i & sh[15]}}, sh[15:0]};
        default: data_o = sh;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_be.sv
// Byte-addressed data memory with sized loads/stores, fault detection, a
// post-reset clear sequence and a 1- or 2-cycle load pipeline.
module data_memory_be
  import data_memory_be_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              memwrite,
  input  logic              memread,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              fault,
  output logic              busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  state_e                  state_q, state_d;
  idx_t                    ptr_q, ptr_d;
  logic [LANES-1:0][7:0]   mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == idx_t'(DEPTH - 1)) state_d = S_READY;
    end
  end

  assign busy = (state_q == S_CLEAR);

  size_e             sz;
  logic [1:0]        lane;
  idx_t              idx;
  logic              oor, mis, bad, accept, st_en;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] st_data;

  assign sz     = size_e'(size);
  assign lane   = addr[1:0];
  assign idx    = addr[IDX_W+1:2];
  assign oor    = |addr[31:IDX_W+2];
  assign bad    = oor | mis;
  assign accept = ~busy & ~rst;
  assign st_en  = accept & memwrite & ~bad;
  assign be     = byte_en(sz, lane);

  always_comb begin
    case (sz)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr[0];
      SZ_WORD: mis = |addr[1:0];
      default: mis = 1'b1;
    endcase
  end

  mem_lane_align u_st_align (
    .load_i    (1'b0),
    .data_i    (write_data),
    .lane_i    (lane),
    .size_i    (sz),
    .unsigned_i(1'b1),
    .data_o    (st_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        mem_q[ptr_q] <= '0;
      end else if (st_en) begin
        for (int unsigned l = 0; l < LANES; l++)
          if (be[l]) mem_q[idx][l] <= st_data[8*l +: 8];
      end
    end
  end

  // Word is sampled combinationally here so a same-cycle store is not visible.
  ld_req_t req_now, ld_src;
  always_comb begin
    req_now       = '0;
    req_now.valid = accept & memread;
    req_now.fault = accept & (memread | memwrite) & bad;
    req_now.lane  = lane;
    req_now.size  = sz;
    req_now.uns   = ld_unsigned;
    req_now.word  = mem_q[idx];
  end

  if (READ_LAT == 2) begin : g_lat2
    ld_req_t pipe_q;
    always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= req_now;
    end
    assign ld_src = pipe_q;
  end else begin : g_lat1
    assign ld_src = req_now;
  end

  logic [DATA_W-1:0] ld_data;
  mem_lane_align u_ld_align (
    .load_i    (1'b1),
    .data_i    (ld_src.word),
    .lane_i    (ld_src.lane),
    .size_i    (ld_src.size),
    .unsigned_i(ld_src.uns),
    .data_o    (ld_data)
  );

  logic [DATA_W-1:0] rd_q;
  logic              rv_q, f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
      rv_q <= 1'b0;
      f_q  <= 1'b0;
    end else begin
      rv_q <= ld_src.valid;
      f_q  <= ld_src.fault;
      if (ld_src.valid) rd_q <= ld_src.fault ? '0 : ld_data;
    end
  end

  assign read_data  = rd_q;
  assign read_valid = rv_q;
  assign fault      = f_q;

endmodule
